// File: rtl/vga_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_ctrl_if
// Description : Host write port (Avalon-style) and PPU register-write port
//               of the VGA frame controller, grouped as one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_ctrl_if;
    logic        avs_write;
    logic [2:0]  avs_address;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic        ppu_write;
    logic [2:0]  ppu_address;
    logic [31:0] ppu_writedata;

    // Host / system side: issues writes, observes the released PPU writes
    modport master (
        output avs_write, avs_address, avs_writedata,
        input  avs_waitrequest, ppu_write, ppu_address, ppu_writedata
    );

    // Frame controller side
    modport slave (
        input  avs_write, avs_address, avs_writedata,
        output avs_waitrequest, ppu_write, ppu_address, ppu_writedata
    );
endinterface
`default_nettype wire

// File: rtl/vga_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_ctrl
// Description : Raster generator, PPU-latency-aligned VGA output stage and
//               vblank-gated sprite-register write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PPU_LAT    = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    vga_frame_ctrl_if.slave        bus,
    output logic [9:0]             hcount,
    output logic [9:0]             vcount,
    input  logic [23:0]            ppu_rgb,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_n,
    output logic                   VGA_SYNC_n,
    output logic                   VGA_CLK,
    output logic                   vblank_irq
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [9:0]  C_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  C_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0]  C_V_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0]  C_V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  C_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  C_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  C_ONE10      = 10'd1;
    localparam logic [AW:0] C_FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] C_CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

    // Raster state
    logic        pix_en_q;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;

    // Sync/blank pipeline: bit 2 = hs, bit 1 = vs, bit 0 = blank (1 = blanked)
    logic [2:0]  w_raw;
    logic [2:0]  w_dly;
    logic        hs_q, vs_q, blank_q;
    logic [23:0] rgb_q;
    logic        irq_q;

    // Write buffer
    logic [34:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          w_full, w_empty, w_in_vblank, w_push, w_pop;
    logic          ppu_write_q;
    logic [2:0]    ppu_address_q;
    logic [31:0]   ppu_writedata_q;

    // Next raster position: advance one pixel on each pixel-enable clk
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == C_H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == C_V_LAST) ? '0 : vcount_q + C_ONE10;
            end else begin
                hcount_d = hcount_q + C_ONE10;
            end
        end
    end

    // Pixel enable toggle and raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign w_raw[2] = ~((hcount_q >= C_HS_START) && (hcount_q < C_HS_END));
    assign w_raw[1] = ~((vcount_q >= C_VS_START) && (vcount_q < C_VS_END));
    assign w_raw[0] = (hcount_q >= C_H_ACTIVE) || (vcount_q >= C_V_ACTIVE);

    // Delay sync/blank by the PPU latency so they line up with ppu_rgb
    generate
        if (PPU_LAT == 0) begin : g_no_delay
            assign w_dly = w_raw;
        end else begin : g_delay
            logic [2:0] dly_q [PPU_LAT];

            // Pixel-tick shift register, resets to syncs inactive / blanked
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PPU_LAT; i++) dly_q[i] <= 3'b111;
                end else if (pix_en_q) begin
                    dly_q[0] <= w_raw;
                    for (int i = 1; i < PPU_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign w_dly = dly_q[PPU_LAT-1];
        end
    endgenerate

    // Output register: aligned sync/blank plus blank-masked colour
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            rgb_q   <= '0;
        end else if (pix_en_q) begin
            hs_q    <= w_dly[2];
            vs_q    <= w_dly[1];
            blank_q <= w_dly[0];
            rgb_q   <= w_dly[0] ? 24'h0 : ppu_rgb;
        end
    end

    // One-clk pulse right after the raster enters the first blank line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= pix_en_q && (hcount_q == C_H_LAST) && (vcount_q == C_V_ACT_LAST);
        end
    end

    assign w_full      = (count_q == C_FIFO_FULL);
    assign w_empty     = (count_q == '0);
    assign w_in_vblank = (vcount_q >= C_V_ACTIVE);
    assign w_push      = bus.avs_write && !w_full;
    assign w_pop       = !w_empty && w_in_vblank;

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (w_pop && !w_push) begin
            count_d = count_q - C_CNT_ONE;
        end
    end

    // Buffer pointers and occupancy; reset flushes all queued writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
            count_q <= count_d;
        end
    end

    // Buffer storage; contents need no reset since occupancy guards them
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= {bus.avs_address, bus.avs_writedata};
    end

    // Release the head entry to the PPU one clk after it is popped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ppu_write_q     <= 1'b0;
            ppu_address_q   <= '0;
            ppu_writedata_q <= '0;
        end else begin
            ppu_write_q <= w_pop;
            if (w_pop) begin
                {ppu_address_q, ppu_writedata_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    assign bus.avs_waitrequest = w_full;
    assign bus.ppu_write       = ppu_write_q;
    assign bus.ppu_address     = ppu_address_q;
    assign bus.ppu_writedata   = ppu_writedata_q;

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_n = ~blank_q;
    assign VGA_SYNC_n  = 1'b0;
    assign VGA_CLK     = pix_en_q;
    assign vblank_irq  = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_ctrl
// Description : Self-checking bench for vga_frame_ctrl on a reduced raster,
//               with a position-based reference model and a queue model of
//               the vblank-gated write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_ctrl;
    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 10, VF = 2, VSW = 2, VB = 2;
    localparam int LAT = 2, DEPTH = 8;
    localparam int HT = HA + HF + HSW + HB;   // 24
    localparam int VT = VA + VF + VSW + VB;   // 16
    localparam int TOT = HT * VT;             // 384 pixels per frame
    localparam int BOUND = 3000;

    typedef struct packed { logic [2:0] a; logic [31:0] d; } ent_t;
    typedef struct packed { logic [2:0] a; logic [31:0] d; logic [9:0] v; } lg_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] ppu_rgb = '0;
    logic [9:0]  hcount, vcount;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, vblank_irq;

    vga_frame_ctrl_if bus();

    vga_frame_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .PPU_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .hcount(hcount), .vcount(vcount), .ppu_rgb(ppu_rgb),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
        .VGA_SYNC_n(VGA_SYNC_n), .VGA_CLK(VGA_CLK), .vblank_irq(vblank_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: n = clk edges since reset release
    longint      n = 0;
    ent_t        fq[$];
    logic        m_pw = 1'b0;
    logic [2:0]  m_pa = '0;
    logic [31:0] m_pd = '0;
    logic [23:0] m_rgb = '0;

    // Observations
    lg_t    log_q[$];
    ent_t   exp_q[$];
    logic   meas_on = 1'b0;
    logic   const_mode = 1'b0;
    int     hs_low_cnt = 0, vs_low_cnt = 0, irq_cnt = 0;
    longint first_vis_n = -1, first_hs_n = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // {hs, vs, blank_n} shown after nn clk edges: the output holds the pixel
    // that was on the raster LAT+1 pixel ticks before the last pixel tick
    function automatic logic [2:0] exp_sync(input longint nn);
        longint j, qp;
        int h, v;
        j = nn / 2;
        if (j - 1 - LAT < 0) return 3'b110;
        qp = (j - 1 - LAT) % TOT;
        h  = int'(qp % HT);
        v  = int'(qp / HT);
        return {!(h >= HA + HF && h < HA + HF + HSW),
                !(v >= VA + VF && v < VA + VF + VSW),
                (h < HA && v < VA)};
    endfunction

    // Reference model, advanced on every active edge
    initial begin : model
        longint cur;
        logic   pop, push;
        ent_t   e;
        logic [2:0] s;
        forever begin
            @(posedge clk);
            if (reset) begin
                n = 0; fq.delete();
                m_pw = 1'b0; m_pa = '0; m_pd = '0; m_rgb = '0;
            end else begin
                cur  = (n / 2) % TOT;
                pop  = (fq.size() > 0) && (cur / HT >= VA);
                push = bus.avs_write && (fq.size() < DEPTH);
                m_pw = pop;
                if (pop) begin
                    e = fq.pop_front();
                    m_pa = e.a; m_pd = e.d;
                end
                if (push) fq.push_back({bus.avs_address, bus.avs_writedata});
                n++;
                if (n % 2 == 0) begin
                    s = exp_sync(n);
                    m_rgb = s[0] ? ppu_rgb : 24'h0;
                end
            end
        end
    end

    // PPU stand-in: random colour per clk, or a fixed colour
    initial begin : ppu_drv
        forever begin
            @(negedge clk);
            ppu_rgb = const_mode ? 24'h123456 : 24'($urandom);
        end
    end

    // Compare process: every cycle, DUT against the model
    initial begin : compare
        longint ep;
        logic   eirq;
        lg_t    l;
        forever begin
            @(negedge clk);
            ep   = (n / 2) % TOT;
            eirq = (n > 0) && (n % 2 == 0) && ((n / 2) % TOT == longint'(VA * HT));
            check("raster", {hcount, vcount, VGA_CLK},
                  {10'(ep % HT), 10'(ep / HT), 1'(n % 2)});
            check("sync", {VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, vblank_irq},
                  {exp_sync(n), 1'b0, eirq});
            check("rgb", {VGA_R, VGA_G, VGA_B}, m_rgb);
            check("bus", {bus.avs_waitrequest, bus.ppu_write, bus.ppu_address, bus.ppu_writedata},
                  {(fq.size() == DEPTH), m_pw, m_pa, m_pd});
            if (bus.ppu_write) begin
                l.a = bus.ppu_address; l.d = bus.ppu_writedata; l.v = vcount;
                log_q.push_back(l);
            end
            if (meas_on && !reset) begin
                if (n >= 1 && n <= 1536) begin
                    if (!VGA_HS) hs_low_cnt++;
                    if (!VGA_VS) vs_low_cnt++;
                    if (vblank_irq) irq_cnt++;
                end
                if (VGA_BLANK_n && first_vis_n < 0) first_vis_n = n;
                if (!VGA_HS && first_hs_n < 0) first_hs_n = n;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Called right after a negedge; returns at the negedge after acceptance
    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        int k;
        k = 0;
        bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
        while (bus.avs_waitrequest && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check("write_accept_timeout", 64'(k < BOUND), 64'd1);
        @(negedge clk);
    endtask

    // ph: 0/1 require that VGA_CLK value, 2 = don't care
    task automatic wait_pos(input int v, input int h, input int ph);
        int k;
        k = 0;
        while (!(vcount == 10'(v) && hcount == 10'(h) && (ph == 2 || VGA_CLK == ph[0]))
               && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check("wait_pos_timeout", 64'(k < BOUND), 64'd1);
    endtask

    initial begin : main
        logic [2:0]  a;
        logic [31:0] d;
        int k;
        bus.avs_write = 1'b0; bus.avs_address = '0; bus.avs_writedata = '0;
        reset = 1'b1;
        meas_on = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state",
              {hcount, vcount, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK,
               bus.ppu_write, bus.avs_waitrequest, vblank_irq, VGA_R, VGA_G, VGA_B},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0});
        reset = 1'b0;

        // Two full frames of raster timing
        repeat (1540) @(negedge clk);
        meas_on = 1'b0;
        // 3 sync px * 16 lines * 2 frames * 2 clk/px
        check("hs_low_clks", 64'(hs_low_cnt), 64'd192);
        // 2 sync lines * 24 px * 2 frames * 2 clk/px
        check("vs_low_clks", 64'(vs_low_cnt), 64'd192);
        check("irq_per_2_frames", 64'(irq_cnt), 64'd2);
        // pixel 0 shows after pixel tick LAT+1 = 3, i.e. clk edge 6
        check("first_visible_edge", 64'(first_vis_n), 64'd6);
        // hcount 18 shows after pixel tick 18+3 = 21, i.e. clk edge 42
        check("first_hsync_edge", 64'(first_hs_n), 64'd42);

        // Constant PPU colour appears only inside the active window
        const_mode = 1'b1;
        repeat (20) @(negedge clk);
        k = 0;
        while (!VGA_BLANK_n && k < BOUND) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        check("const_colour", {VGA_BLANK_n, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h123456});
        const_mode = 1'b0;

        // Single write in active video is held until vblank
        log_q.delete();
        wait_pos(3, 0, 2);
        host_write(3'd3, 32'h00640050);
        bus.avs_write = 1'b0;
        wait_pos(VA - 1, HT - 1, 2);
        check("no_write_before_vblank", 64'(log_q.size()), 64'd0);
        wait_pos(VA + 1, 0, 2);
        check("single_write_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0)
            check("single_write", {log_q[0].a, log_q[0].d, log_q[0].v},
                  {3'd3, 32'h00640050, 10'(VA)});

        // Nine back-to-back writes into an eight-deep buffer
        log_q.delete(); exp_q.delete();
        wait_pos(1, 0, 2);
        for (int i = 0; i < 9; i++) begin
            a = 3'($urandom); d = $urandom;
            exp_q.push_back({a, d});
            host_write(a, d);
            if (i == 7) check("waitreq_after_8", 64'(bus.avs_waitrequest), 64'd1);
        end
        bus.avs_write = 1'b0;
        wait_pos(VA + 1, 0, 2);
        check("burst9_count", 64'(log_q.size()), 64'd9);
        for (int i = 0; i < 9 && i < log_q.size(); i++)
            check("burst9_order", {log_q[i].a, log_q[i].d}, exp_q[i]);

        // Four queued at vblank entry, then push and pop together each clk
        log_q.delete(); exp_q.delete();
        wait_pos(VA - 1, HT - 2, 0);
        for (int i = 0; i < 12; i++) begin
            a = 3'($urandom); d = $urandom;
            exp_q.push_back({a, d});
            host_write(a, d);
        end
        bus.avs_write = 1'b0;
        wait_pos(VA + 1, 0, 2);
        check("pushpop_count", 64'(log_q.size()), 64'd12);
        for (int i = 0; i < 12 && i < log_q.size(); i++)
            check("pushpop_order", {log_q[i].a, log_q[i].d}, exp_q[i]);

        // Random writes with random gaps across frames
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            host_write(3'($urandom), $urandom);
            bus.avs_write = 1'b0;
        end
        repeat (4 * TOT) @(negedge clk);

        // Reset mid-frame with writes queued
        wait_pos(2, 0, 2);
        for (int i = 0; i < 5; i++) host_write(3'($urandom), $urandom);
        bus.avs_write = 1'b0;
        wait_pos(5, 7, 2);
        #1 reset = 1'b1;
        #1;
        check("async_reset",
              {hcount, vcount, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK,
               bus.ppu_write, bus.avs_waitrequest, vblank_irq},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        wait_pos(VA + 2, 0, 2);
        check("flushed_no_ppu_write", 64'(log_q.size()), 64'd0);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
